cla_seq_adder: RTL and testbench

CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

---
 rtl/cla_seq_pkg.sv | 17 +
 rtl/cla4_slice.sv | 32 +++
 rtl/cla_seq_adder.sv | 125 ++++++++++++
 tb/tb_cla_seq_adder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder.
package cla_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of 4-bit slices needed to cover an operand of the given width.
  function automatic int nibble_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
module cla4_slice
  import cla_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  // Per-bit generate and propagate terms.
  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded directly from g/p and ci, so no carry ripples between bits.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  // Sum bits and slice carry-out.
  assign s  = p ^ c[SLICE_W-1:0];
  assign co = c[SLICE_W];

endmodule

// File: rtl/cla_seq_adder.sv
// Sequential adder/subtractor that time-shares one 4-bit CLA slice, LSB nibble first.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB   = nibble_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t state;
  state_t state_next;

  // Operands and result are held as nibble arrays so the index selects a slice directly.
  logic [NIB-1:0][SLICE_W-1:0] a_reg;
  logic [NIB-1:0][SLICE_W-1:0] b_reg;
  logic [NIB-1:0][SLICE_W-1:0] sum_reg;
  logic                        carry_reg;
  logic                        cout_reg;
  logic                        ovf_reg;
  logic [IDX_W-1:0]            idx;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;
  logic               last_nib;
  logic               a_msb;
  logic               b_msb;

  assign last_nib = (idx == IDX_W'(NIB - 1));
  assign a_msb    = a_reg[NIB-1][SLICE_W-1];
  assign b_msb    = b_reg[NIB-1][SLICE_W-1];

  cla4_slice u_slice (
    .a  (a_reg[idx]),
    .b  (b_reg[idx]),
    .ci (carry_reg),
    .s  (slice_s),
    .co (slice_co)
  );

  // Next-state and handshake decode; DONE blocks new accepts until the result is taken.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand capture on accept, one nibble per RUN cycle, flags latched on the final nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub | cin;
            idx       <= '0;
          end
        end
        RUN: begin
          sum_reg[idx] <= slice_s;
          carry_reg    <= slice_co;
          if (last_nib) begin
            cout_reg <= slice_co;
            ovf_reg  <= (a_msb == b_msb) && (slice_s[SLICE_W-1] != a_msb);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed-vector bench for the nibble-serial CLA adder.
module tb_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_sub;
    logic        op_cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Drives one operation from IDLE, scrambles inputs while running, returns observed result and latency.
  task automatic do_op(input logic [15:0] op_a, input logic [15:0] op_b,
                       input logic op_sub, input logic op_cin,
                       output logic [15:0] r_sum, output logic r_cout,
                       output logic r_ovf, output int lat);
    a = op_a; b = op_b; sub = op_sub; cin = op_cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      sub = 1'($urandom);
      cin = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    r_sum  = sum;
    r_cout = cout;
    r_ovf  = ovf;
  endtask

  // Hands the result off with a one-cycle out_ready pulse.
  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'h0; b = 16'h0; sub = 1'b0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL reset_handshake: got %b expected 100", {in_ready, out_valid, busy});
    end
    vectors++;
    if ({sum, cout, ovf} !== 18'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_result: got %h expected 0", {sum, cout, ovf});
    end
  endtask

  task automatic test_vectors();
    vec_t tbl[7];
    logic [15:0] r_sum;
    logic r_cout, r_ovf;
    int lat;
    tbl[0] = '{16'h0005, 16'hFFFD, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tbl[4] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[6] = '{16'h0010, 16'h0001, 1'b1, 1'b0, 16'h000F, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].op_a, tbl[i].op_b, tbl[i].op_sub, tbl[i].op_cin, r_sum, r_cout, r_ovf, lat);
      vectors++;
      if (lat !== 4) begin
        miscompares++;
        $display("[TB] FAIL vec%0d_latency: got %0d expected 4", i, lat);
      end
      vectors++;
      if (r_sum !== tbl[i].exp_sum) begin
        miscompares++;
        $display("[TB] FAIL vec%0d_sum: got %h expected %h", i, r_sum, tbl[i].exp_sum);
      end
      vectors++;
      if (r_cout !== tbl[i].exp_cout) begin
        miscompares++;
        $display("[TB] FAIL vec%0d_cout: got %b expected %b", i, r_cout, tbl[i].exp_cout);
      end
      vectors++;
      if (r_ovf !== tbl[i].exp_ovf) begin
        miscompares++;
        $display("[TB] FAIL vec%0d_ovf: got %b expected %b", i, r_ovf, tbl[i].exp_ovf);
      end
      release_result();
    end
  endtask

  task automatic test_hold();
    logic [15:0] r_sum;
    logic r_cout, r_ovf;
    int lat;
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, r_sum, r_cout, r_ovf, lat);
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom); b = 16'($urandom); in_valid = ~in_valid;
      @(posedge clk); #1;
      vectors++;
      if ({sum, cout, ovf, in_ready, out_valid} !== {16'h5555, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL hold_cycle%0d: got %h expected %h", i,
                 {sum, cout, ovf, in_ready, out_valid}, {16'h5555, 4'b0001});
      end
    end
    in_valid = 1'b0;
    release_result();
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL hold_release: got %b expected 100", {in_ready, out_valid, busy});
    end
    vectors++;
    if (sum !== 16'h5555) begin
      miscompares++;
      $display("[TB] FAIL hold_retain_sum: got %h expected 5555", sum);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] r_sum;
    logic r_cout, r_ovf;
    int lat;
    bit seen;
    a = 16'h1111; b = 16'h1111; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_busy: got %b expected 1", busy);
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, 18'h0}) begin
      miscompares++;
      $display("[TB] FAIL abort_state: got %h expected %h",
               {in_ready, out_valid, busy, sum, cout, ovf}, {3'b100, 18'h0});
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_no_valid: got %b expected 0", seen);
    end
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, r_sum, r_cout, r_ovf, lat);
    vectors++;
    if ({lat[7:0], r_sum, r_cout, r_ovf} !== {8'd4, 16'h0100, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL abort_followup: got %h expected %h",
               {lat[7:0], r_sum, r_cout, r_ovf}, {8'd4, 16'h0100, 2'b00});
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [15:0] r_sum;
    logic r_cout, r_ovf;
    int lat;
    do_op(16'hABCD, 16'hABCD, 1'b1, 1'b0, r_sum, r_cout, r_ovf, lat);
    vectors++;
    if ({lat[7:0], r_sum, r_cout, r_ovf} !== {8'd4, 16'h0000, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got %h expected %h",
               {lat[7:0], r_sum, r_cout, r_ovf}, {8'd4, 16'h0000, 2'b10});
    end
    release_result();
    do_op(16'h8000, 16'h8000, 1'b0, 1'b1, r_sum, r_cout, r_ovf, lat);
    vectors++;
    if ({lat[7:0], r_sum, r_cout, r_ovf} !== {8'd4, 16'h0001, 1'b1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got %h expected %h",
               {lat[7:0], r_sum, r_cout, r_ovf}, {8'd4, 16'h0001, 2'b11});
    end
    release_result();
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
